// File: rtl/dec_loop_ctrl.sv
// dec_loop_ctrl
//   Iteration-counter stage wrapped around an external combinational DEC
//   component. The current count is registered on a and fed to the DEC; the
//   DEC result d is written back on every step. done pulses for one cycle
//   when the count has been run down to zero.
//
// Ports
//   Clk        rising-edge clock
//   Rst        asynchronous, active-low reset
//   start      load init and begin counting (sampled in IDLE only)
//   init       initial count
//   step       advance one iteration while RUN
//   abort      cancel the run and return to IDLE (wins over step)
//   d          DEC result, expected to equal a-1
//   a          registered current count, drives DEC input a
//   iter       registered number of steps taken this run
//   busy       high while in RUN
//   done       high for the single cycle spent in DONE
//   dbg_state  raw state register (IDLE=00, RUN=01, DONE=10)
//
// Handshake: start is a single-cycle request that is accepted only when the
// block is in IDLE; step is a qualifier that is consumed on every clock edge
// in RUN where it is high. There is no back-pressure.

module dec_loop_ctrl #(
  parameter int DATAWIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] init,
  input  logic                 step,
  input  logic                 abort,
  input  logic [DATAWIDTH-1:0] d,
  output logic [DATAWIDTH-1:0] a,
  output logic [DATAWIDTH-1:0] iter,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  localparam logic [DATAWIDTH-1:0] ONE = DATAWIDTH'(1);

  logic [1:0]           state_q, state_d;
  logic [DATAWIDTH-1:0] a_q, a_d;
  logic [DATAWIDTH-1:0] iter_q, iter_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = init;
          iter_d  = '0;
          state_d = (init == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (step) begin
          a_d    = d;
          iter_d = iter_q + ONE;
          // Exit on the registered count so the DEC output never has to be
          // trusted for control; a==1 means this step takes it to zero.
          if (a_q == ONE) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        a_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      iter_q  <= iter_d;
    end
  end

  // Pure decodes of the state register, so no combinational glitches.
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign a         = a_q;
  assign iter      = iter_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dec_loop_ctrl.sv
module tb_dec_loop_ctrl;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] init = '0;
  logic         step = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] d;
  logic [W-1:0] a;
  logic [W-1:0] iter;
  logic         busy;
  logic         done;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // external DEC component
  assign d = a - 8'd1;

  always #5 Clk = ~Clk;

  dec_loop_ctrl #(.DATAWIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .init(init), .step(step),
    .abort(abort), .d(d), .a(a), .iter(iter), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({a, iter, busy, done, dbg_state} !== {8'd0, 8'd0, 1'b0, 1'b0, 2'b00}) begin
      n_errors++;
      $display("FAIL reset_init: a=%0d iter=%0d busy=%b done=%b st=%b, want 0 0 0 0 00",
               a, iter, busy, done, dbg_state);
    end
    Rst = 1'b1;
    tick();
    // start a run, then assert reset mid-cycle with no edge
    start = 1'b1; init = 8'd10; step = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (busy !== 1'b1 || a !== 8'd7 || iter !== 8'd3) begin
      n_errors++;
      $display("FAIL reset_prerun: busy=%b a=%0d iter=%0d, want 1 7 3", busy, a, iter);
    end
    #2 Rst = 1'b0;
    #1;
    n_checks++;
    if ({a, iter, busy, done} !== {8'd0, 8'd0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_async: a=%0d iter=%0d busy=%b done=%b, want 0 0 0 0",
               a, iter, busy, done);
    end
    step = 1'b0;
    tick();
    Rst = 1'b1;
    tick();
  endtask

  task automatic test_count10();
    int busy_cycles = 0;
    int done_cycles = 0;
    start = 1'b1; init = 8'd10; step = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) tick();
      if (busy) busy_cycles++;
      if (done) done_cycles++;
      n_checks++;
      if (k < 10) begin
        if (busy !== 1'b1 || done !== 1'b0 || a !== 8'(10 - k) || iter !== 8'(k)) begin
          n_errors++;
          $display("FAIL count10_k%0d: busy=%b done=%b a=%0d iter=%0d, want 1 0 %0d %0d",
                   k, busy, done, a, iter, 10 - k, k);
        end
      end else begin
        if (busy !== 1'b0 || done !== 1'b1 || a !== 8'd0 || iter !== 8'd10) begin
          n_errors++;
          $display("FAIL count10_done: busy=%b done=%b a=%0d iter=%0d, want 0 1 0 10",
                   busy, done, a, iter);
        end
      end
    end
    tick();
    step = 1'b0;
    if (busy) busy_cycles++;
    if (done) done_cycles++;
    n_checks++;
    if (dbg_state !== 2'b00 || busy_cycles != 10 || done_cycles != 1) begin
      n_errors++;
      $display("FAIL count10_end: st=%b busy_cycles=%0d done_cycles=%0d, want 00 10 1",
               dbg_state, busy_cycles, done_cycles);
    end
  endtask

  task automatic test_zero_and_back_to_back();
    start = 1'b1; init = 8'd0;
    tick();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || iter !== 8'd0 || a !== 8'd0) begin
      n_errors++;
      $display("FAIL zero_done: done=%b busy=%b iter=%0d a=%0d, want 1 0 0 0",
               done, busy, iter, a);
    end
    // start held through DONE must be ignored there
    init = 8'd3;
    tick();
    n_checks++;
    if (dbg_state !== 2'b00 || done !== 1'b0 || busy !== 1'b0 || a !== 8'd0) begin
      n_errors++;
      $display("FAIL zero_idle: st=%b done=%b busy=%b a=%0d, want 00 0 0 0",
               dbg_state, done, busy, a);
    end
    tick();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || a !== 8'd3 || iter !== 8'd0) begin
      n_errors++;
      $display("FAIL b2b_start: busy=%b a=%0d iter=%0d, want 1 3 0", busy, a, iter);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_alternate_step();
    start = 1'b1; init = 8'd5; step = 1'b0;
    tick();
    start = 1'b0;
    // step on odd cycles 1,3,5,7,9; 5th step lands on edge 9
    for (int k = 1; k <= 9; k++) begin
      step = k[0];
      tick();
      if (k < 9) begin
        n_checks++;
        if (busy !== 1'b1 || a !== 8'(5 - (k + 1) / 2) || iter !== 8'((k + 1) / 2)) begin
          n_errors++;
          $display("FAIL alt_k%0d: busy=%b a=%0d iter=%0d, want 1 %0d %0d",
                   k, busy, a, iter, 5 - (k + 1) / 2, (k + 1) / 2);
        end
      end
    end
    step = 1'b0;
    n_checks++;
    if (done !== 1'b1 || a !== 8'd0 || iter !== 8'd5) begin
      n_errors++;
      $display("FAIL alt_done: done=%b a=%0d iter=%0d, want 1 0 5", done, a, iter);
    end
    tick();
  endtask

  task automatic test_abort();
    int done_seen = 0;
    start = 1'b1; init = 8'd7; step = 1'b0;
    tick();
    start = 1'b0; step = 1'b1;
    repeat (3) tick();
    abort = 1'b1;
    tick();
    if (done) done_seen++;
    abort = 1'b0; step = 1'b0;
    n_checks++;
    if (dbg_state !== 2'b00 || a !== 8'd4 || iter !== 8'd3 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL abort: st=%b a=%0d iter=%0d busy=%b, want 00 4 3 0",
               dbg_state, a, iter, busy);
    end
    repeat (2) begin
      tick();
      if (done) done_seen++;
    end
    n_checks++;
    if (done_seen != 0 || a !== 8'd4 || iter !== 8'd3) begin
      n_errors++;
      $display("FAIL abort_hold: done_seen=%0d a=%0d iter=%0d, want 0 4 3",
               done_seen, a, iter);
    end
  endtask

  task automatic test_start_ignored_and_max();
    int cyc;
    start = 1'b1; init = 8'd9; step = 1'b0;
    tick();
    start = 1'b0; step = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (a !== 8'd6) begin
      n_errors++;
      $display("FAIL ign_pre: a=%0d, want 6", a);
    end
    start = 1'b1; init = 8'd99;
    tick();
    start = 1'b0;
    n_checks++;
    if (a !== 8'd5 || iter !== 8'd4 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL ign_start: a=%0d iter=%0d busy=%b, want 5 4 1", a, iter, busy);
    end
    tick();
    n_checks++;
    if (a !== 8'd4) begin
      n_errors++;
      $display("FAIL ign_cont: a=%0d, want 4", a);
    end
    repeat (4) tick();
    n_checks++;
    if (done !== 1'b1 || iter !== 8'd9) begin
      n_errors++;
      $display("FAIL ign_done: done=%b iter=%0d, want 1 9", done, iter);
    end
    tick();
    // full-range run
    start = 1'b1; init = 8'd255;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 300) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (done !== 1'b1 || cyc != 255 || iter !== 8'd255 || a !== 8'd0) begin
      n_errors++;
      $display("FAIL max_run: done=%b cycles=%0d iter=%0d a=%0d, want 1 255 255 0",
               done, cyc, iter, a);
    end
    step = 1'b0;
    tick();
    n_checks++;
    if (dbg_state !== 2'b00 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL max_idle: st=%b done=%b, want 00 0", dbg_state, done);
    end
  endtask

  initial begin
    test_reset();
    test_count10();
    test_zero_and_back_to_back();
    test_alternate_step();
    test_abort();
    test_start_ignored_and_max();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
